// File: rtl/pwm_dac_bs_pkg.sv
// Shared definitions for the SAR/DAC blocks: FSM states and default code width.
// Consumed by pwm_dac_bs and pwm_dac_cmp.
package pwm_dac_bs_pkg;

    localparam int unsigned DefWidth = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/pwm_dac_cmp.sv
// Window comparator: maps cycle count and code to the PWM level.
// PWM_DAC_CENTER_EN selects center-aligned pulses; default is left-aligned.
module pwm_dac_cmp
    import pwm_dac_bs_pkg::*;
#(
    parameter int unsigned Width = DefWidth
) (
    input  logic             en_i,
    input  logic [Width-1:0] cnt_i,
    input  logic [Width-1:0] code_i,
    output logic             pwm_o
);

`ifdef PWM_DAC_CENTER_EN
    localparam logic [Width:0] Full = {1'b1, {Width{1'b0}}};

    logic [Width:0] lo;
    logic [Width:0] hi;
    logic [Width:0] cnt_x;
    logic [Width:0] code_x;

    // Pulse sits in the middle of the period: lo <= cnt < lo + code
    always_comb begin
        code_x = {1'b0, code_i};
        cnt_x  = {1'b0, cnt_i};
        lo     = (Full - code_x) >> 1;
        hi     = lo + code_x;
        pwm_o  = en_i && (cnt_x >= lo) && (cnt_x < hi);
    end
`else
    // Pulse starts at the beginning of the period
    always_comb begin
        pwm_o = en_i && (cnt_i < code_i);
    end
`endif

endmodule

// File: rtl/pwm_dac_bs.sv
// PWM DAC: IDLE -> SAMPLE -> RUN (Periods x 2^Width cycles) -> DONE.
// Optional macro PWM_DAC_CENTER_EN selects center-aligned pulses.
module pwm_dac_bs
    import pwm_dac_bs_pkg::*;
#(
    parameter int unsigned Width   = DefWidth,
    parameter int unsigned Periods = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [Width-1:0] code_i,
    output logic             pwm_o,
    output logic [Width-1:0] code_o,
    output logic             sample_o,
    output logic             ready_o,
    output logic             done_o
);

    localparam logic [Width-1:0] CntMax  = '1;
    localparam logic [Width-1:0] PerLast = Width'(Periods - 1);

    state_e           state_q;
    state_e           state_d;
    logic [Width-1:0] cnt_q;
    logic [Width-1:0] per_q;
    logic [Width-1:0] code_q;
    logic             last;
    logic             run;

    assign last   = (cnt_q == CntMax) && (per_q == PerLast);
    assign code_o = code_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = SAMPLE;
            SAMPLE:  state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        ready_o  = 1'b0;
        sample_o = 1'b0;
        done_o   = 1'b0;
        run      = 1'b0;
        unique case (state_q)
            IDLE:    ready_o  = 1'b1;
            SAMPLE:  sample_o = 1'b1;
            RUN:     run      = 1'b1;
            DONE:    done_o   = 1'b1;
            default: ready_o  = 1'b0;
        endcase
    end

    // Code latch, cycle counter and period counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            per_q  <= '0;
            code_q <= '0;
        end else if (state_q == SAMPLE) begin
            cnt_q  <= '0;
            per_q  <= '0;
            code_q <= code_i;
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntMax) begin
                per_q <= per_q + 1'b1;
            end
        end
    end

    pwm_dac_cmp #(
        .Width (Width)
    ) u_cmp (
        .en_i   (run),
        .cnt_i  (cnt_q),
        .code_i (code_q),
        .pwm_o  (pwm_o)
    );

endmodule

// File: doc/pwm_dac_bs.md
PWM_DAC_BS -- requirements
Module: pwm_dac_bs

Interface
REQ-001 SHALL have parameter Width, default 6: code width; PWM period is 2^Width cycles.
REQ-002 SHALL have parameter Periods, default 1: PWM periods generated per start; legal range 1..2^Width.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port start_i, input, 1: request a conversion; sampled only in IDLE.
REQ-006 SHALL have port code_i, input, Width: digital code to convert; latched during SAMPLE.
REQ-007 SHALL have port pwm_o, output, 1: PWM bitstream driving the analog filter.
REQ-008 SHALL have port code_o, output, Width: code currently being converted.
REQ-009 SHALL have port sample_o, output, 1: high for the single SAMPLE cycle.
REQ-010 SHALL have port ready_o, output, 1: high in IDLE only.
REQ-011 SHALL have port done_o, output, 1: one-cycle pulse in DONE.

Function
REQ-012 SHALL implement FSM states IDLE, SAMPLE, RUN, DONE.
REQ-013 SHALL transition IDLE->SAMPLE on a rising edge with start_i=1, and stay in IDLE otherwise.
REQ-014 SHALL transition SAMPLE->RUN unconditionally, latch code_i into code_o, and clear the cycle counter cnt (Width bits) and the period counter per.
REQ-015 SHALL increment cnt every RUN cycle, wrapping 2^Width-1 -> 0, and increment per on each wrap.
REQ-016 SHALL transition RUN->DONE on the cycle where cnt = 2^Width-1 and per = Periods-1, so RUN lasts exactly Periods*2^Width cycles.
REQ-017 SHALL transition DONE->IDLE unconditionally, with done_o=1 for exactly that cycle.
REQ-018 SHALL, in left-aligned mode, drive pwm_o = 1 iff state = RUN and cnt < code_o, combinational from registers with no added latency.
REQ-019 SHALL hold pwm_o = 0 in IDLE, SAMPLE and DONE.
REQ-020 SHALL, for code 0, never assert pwm_o; for code 2^Width-1, assert pwm_o for 2^Width-1 of every 2^Width RUN cycles.
REQ-021 SHALL ignore start_i outside IDLE, and code_i outside SAMPLE.
REQ-022 SHALL hold code_o stable from the end of SAMPLE until the next SAMPLE, remaining valid through IDLE.
REQ-023 SHALL, when start_i is held high continuously, produce back-to-back conversions separated by one DONE and one IDLE cycle.

Reset
REQ-024 SHALL, on rst_ni = 0 at a clock edge, force state IDLE, cnt = 0, per = 0, code_o = 0; resulting outputs pwm_o = 0, sample_o = 0, done_o = 0, ready_o = 1.
REQ-025 SHALL, on reset asserted mid-RUN, abort the conversion without a done_o pulse; pwm_o is low from the first cycle after the reset edge.

Configuration
REQ-026 SHALL support macro PWM_DAC_CENTER_EN: when defined, pulses are center-aligned: pwm_o = 1 iff state = RUN and lo <= cnt < lo+code_o, where lo = (2^Width - code_o) >> 1, computed at Width+1 bits.
REQ-027 SHALL, when PWM_DAC_CENTER_EN is undefined, use left-aligned mode (REQ-018); duty per period is identical in both modes.

Structure
REQ-028 SHALL take the state encodings (IDLE, SAMPLE, RUN, DONE) and the default Width from the shared package used by the SAR blocks.
REQ-029 SHALL isolate the window comparison (cnt, code -> pwm level, including centering) in sub-module pwm_dac_cmp; the FSM and counters stay in pwm_dac_bs.

Verification
REQ-030 SHALL cover left-aligned operation: Width=6, Periods=2, code_i=16, start pulse -> sample_o 1 cycle; pwm_o high RUN cycles 0-15 and 64-79; RUN 128 cycles; done_o 1 cycle; ready_o returns.
REQ-031 SHALL cover code extremes: code_i=0 -> pwm_o never high; code_i=63 -> pwm_o low only at cnt=63.
REQ-032 SHALL cover PWM_DAC_CENTER_EN: code_i=16 -> pwm_o high at cnt 24-39 each period; code_i=63 -> high at cnt 0-62.
REQ-033 SHALL cover reset abort: rst_ni=0 at RUN cycle 10 -> next cycle IDLE, pwm_o=0, no done_o, code_o=0.
REQ-034 SHALL cover input isolation: code_i changed and start_i pulsed during RUN -> code_o unchanged, no restart, single done_o.
REQ-035 SHALL cover continuous start: start_i held high -> conversions repeat with exactly one DONE cycle and one IDLE cycle between RUN phases.
